// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// slave  : arbiter side (takes requests and read data, drives acks and memory controls)
// master : environment side (requesters plus memory model)
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic              err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write, mem_read;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, err0, err1, rdata0, rdata1,
           mem_addr, mem_wdata, mem_write, mem_read
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
           mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a combinational big-endian 32-bit
// data memory. Every output is registered so the memory sees address, data
// and strobes stable for a whole cycle. One access takes IDLE->ACCESS->DONE.
// Optional macro ALIGN_CHECK_EN: misaligned or out-of-range word addresses
// are refused at grant (no strobe, rdata cleared, err pulsed with ack).
module data_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  data_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  if (MEM_BYTES % 4 != 0 || MEM_BYTES < 4) begin : g_bad_size
    $error("MEM_BYTES must be a positive multiple of 4");
  end

  state_t                   state, state_nxt;
  logic                     rr_ptr, owner, we_q, bad_q;
  logic [1:0]               req, ack, err;
  logic [1:0][DATA_W-1:0]   rdata;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_write, mem_read;

  logic                     grant_own, grant_we, grant_bad;
  logic [ADDR_W-1:0]        grant_addr;
  logic [DATA_W-1:0]        grant_wdata;

  assign req = {bus.req1, bus.req0};

  // Pick the owner for a grant this edge: a lone requester wins, a tie goes to rr_ptr.
  always_comb begin
    grant_own   = (req == 2'b11) ? rr_ptr : req[1];
    grant_we    = grant_own ? bus.we1    : bus.we0;
    grant_addr  = grant_own ? bus.addr1  : bus.addr0;
    grant_wdata = grant_own ? bus.wdata1 : bus.wdata0;
  end

`ifdef ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);
  // Refuse addresses that are not word aligned or would run off the end of memory.
  always_comb grant_bad = (grant_addr[1:0] != 2'b00) || (grant_addr > LAST_WORD);
`else
  // Every address goes to memory unchanged.
  always_comb grant_bad = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a grant in IDLE runs one ACCESS cycle and one DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered datapath: latch at grant, complete at ACCESS exit, rotate priority at DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      we_q      <= 1'b0;
      bad_q     <= 1'b0;
      ack       <= '0;
      err       <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        IDLE: if (|req) begin
          owner     <= grant_own;
          we_q      <= grant_we;
          bad_q     <= grant_bad;
          mem_addr  <= grant_addr;
          mem_wdata <= grant_wdata;
          mem_write <= grant_we  & ~grant_bad;
          mem_read  <= ~grant_we & ~grant_bad;
        end
        ACCESS: begin
          mem_write  <= 1'b0;
          mem_read   <= 1'b0;
          ack[owner] <= 1'b1;
          err[owner] <= bad_q;
          if (bad_q)      rdata[owner] <= '0;
          else if (!we_q) rdata[owner] <= bus.mem_rdata;
        end
        DONE:    rr_ptr <= ~owner;
        default: ;
      endcase
    end
  end

  assign bus.ack0      = ack[0];
  assign bus.ack1      = ack[1];
  assign bus.err0      = err[0];
  assign bus.err1      = err[1];
  assign bus.rdata0    = rdata[0];
  assign bus.rdata1    = rdata[1];
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_write = mem_write;
  assign bus.mem_read  = mem_read;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: byte-array memory, transaction-level reference
// model compared every cycle, directed literal checks, then random traffic.
module tb_data_mem_arbiter;
  localparam int ADDR_W = 32, DATA_W = 32, MEM_BYTES = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int bi(input logic [31:0] a, input int i);
    logic [31:0] s;
    s = a + 32'(i);
    return int'(s % 32'(MEM_BYTES));
  endfunction

  // ---------------- memory (combinational read, write at edge) ----------------
  logic [7:0]  mem [MEM_BYTES];
  logic        pl_en = 1'b0;
  logic [31:0] pl_addr = '0, pl_data = '0;

  assign bus.mem_rdata = {mem[bi(bus.mem_addr, 0)], mem[bi(bus.mem_addr, 1)],
                          mem[bi(bus.mem_addr, 2)], mem[bi(bus.mem_addr, 3)]};

  always @(posedge clk) begin
    if (pl_en)
      for (int i = 0; i < 4; i++) mem[bi(pl_addr, i)] <= pl_data[31-8*i -: 8];
    else if (bus.mem_write)
      for (int i = 0; i < 4; i++) mem[bi(bus.mem_addr, i)] <= bus.mem_wdata[31-8*i -: 8];
  end

  // ---------------- reference model ----------------
  // Timeline view: a grant occupies three edges (grant, complete, release);
  // a new grant is possible only once the previous one has been released.
  logic [7:0]  ref_mem [MEM_BYTES];
  int          busy;
  logic        m_rr, p_own, p_we, p_bad;
  logic [31:0] p_addr, p_wdata, newd;
  logic        e_ack0, e_ack1, e_err0, e_err1, e_wr, e_rd;
  logic [31:0] e_rd0, e_rd1, e_maddr, e_mwdata;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[bi(a, 0)], ref_mem[bi(a, 1)], ref_mem[bi(a, 2)], ref_mem[bi(a, 3)]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 0; m_rr = 0;
      e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0; e_wr = 0; e_rd = 0;
      e_rd0 = 0; e_rd1 = 0; e_maddr = 0; e_mwdata = 0;
    end else begin
      e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0;
      if (pl_en) for (int i = 0; i < 4; i++) ref_mem[bi(pl_addr, i)] = pl_data[31-8*i -: 8];
      if (busy == 0) begin
        if (bus.req0 || bus.req1) begin
          p_own   = (bus.req0 && bus.req1) ? m_rr : bus.req1;
          p_we    = p_own ? bus.we1    : bus.we0;
          p_addr  = p_own ? bus.addr1  : bus.addr0;
          p_wdata = p_own ? bus.wdata1 : bus.wdata0;
`ifdef ALIGN_CHECK_EN
          p_bad = (p_addr % 4 != 0) || (p_addr > 32'(MEM_BYTES - 4));
`else
          p_bad = 1'b0;
`endif
          e_maddr = p_addr; e_mwdata = p_wdata;
          e_wr = p_we && !p_bad;
          e_rd = !p_we && !p_bad;
          busy = 2;
        end
      end else if (busy == 2) begin
        e_wr = 0; e_rd = 0;
        newd = p_bad ? 32'h0 : ref_word(p_addr);
        if (p_we && !p_bad)
          for (int i = 0; i < 4; i++) ref_mem[bi(p_addr, i)] = p_wdata[31-8*i -: 8];
        if (p_own) begin
          e_ack1 = 1; e_err1 = p_bad;
          if (p_bad || !p_we) e_rd1 = newd;
        end else begin
          e_ack0 = 1; e_err0 = p_bad;
          if (p_bad || !p_we) e_rd0 = newd;
        end
        busy = 1;
      end else begin
        busy = 0;
        m_rr = !p_own;
      end
    end
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    chk("ack0", bus.ack0, e_ack0);
    chk("ack1", bus.ack1, e_ack1);
    chk("err0", bus.err0, e_err0);
    chk("err1", bus.err1, e_err1);
    chk("rdata0", bus.rdata0, e_rd0);
    chk("rdata1", bus.rdata1, e_rd1);
    chk("mem_write", bus.mem_write, e_wr);
    chk("mem_read", bus.mem_read, e_rd);
    chk("mem_addr", bus.mem_addr, e_maddr);
    chk("mem_wdata", bus.mem_wdata, e_mwdata);
    chk("strobe_excl", bus.mem_write & bus.mem_read, 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input bit p, input bit we, input logic [31:0] a, input logic [31:0] wd);
    if (p) begin bus.req1 = 1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; end
    else   begin bus.req0 = 1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] odd [5];
    odd[0] = 1; odd[1] = 2; odd[2] = 3; odd[3] = 4093; odd[4] = 4094;
    if ($urandom_range(0, 7) == 0) return odd[$urandom_range(0, 4)];
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  task automatic rnd_req(input bit p);
    set_req(p, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
  endtask

  task automatic do_access(input bit p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output logic [1:0] strb,
                           output int lat);
    set_req(p, we, a, wd);
    lat = 0; strb = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) strb = {bus.mem_write, bus.mem_read};
    end while (!(p ? bus.ack1 : bus.ack0) && lat < 20);
    rd = p ? bus.rdata1 : bus.rdata0;
    er = p ? bus.err1 : bus.err0;
    if (p) bus.req1 = 0; else bus.req0 = 0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  logic [31:0] rd;
  logic        er;
  logic [1:0]  strb;
  int          lat, nack, last_t, cyc;
  int          order [8];

  initial begin
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_ack0", bus.ack0, 0);
    chk("rst_rdata0", bus.rdata0, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    rst_n = 1;
    @(negedge clk);

    // Preload words 0..63 and the last word; word 0 holds bytes 00 00 00 06.
    for (int w = 0; w < 65; w++) begin
      pl_en = 1;
      pl_addr = (w == 64) ? 32'd4092 : 32'(w * 4);
      pl_data = (w == 0) ? 32'h0000_0006 : $urandom;
      @(negedge clk);
    end
    pl_en = 0;
    @(negedge clk);

    // Plain read on port 0.
    do_access(0, 0, 0, 0, rd, er, strb, lat);
    chk("t2_strobe", strb, 2'b01);
    chk("t2_latency", lat, 2);
    chk("t2_rdata0", rd, 32'h0000_0006);

    // Write then read back on port 1.
    do_access(1, 1, 16, 32'hDEAD_BEEF, rd, er, strb, lat);
    chk("t3_wr_strobe", strb, 2'b10);
    chk("t3_wr_latency", lat, 2);
    do_access(1, 0, 16, 0, rd, er, strb, lat);
    chk("t3_rdata1", rd, 32'hDEAD_BEEF);

    // Contention: both held and reissued on ack -> 0,1,0,1 at 3-cycle spacing.
    pulse_reset();
    set_req(0, 0, 32'h40, 0);
    set_req(1, 0, 32'h80, 0);
    nack = 0; last_t = 0;
    for (int t = 1; t <= 60 && nack < 8; t++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) begin
        order[nack] = bus.ack1 ? 1 : 0;
        if (nack > 0) chk("t4_spacing", t - last_t, 3);
        last_t = t;
        nack++;
        if (bus.ack0) set_req(0, 0, 32'($urandom_range(0, 63)) << 2, 0);
        if (bus.ack1) set_req(1, 0, 32'($urandom_range(0, 63)) << 2, 0);
      end
    end
    bus.req0 = 0; bus.req1 = 0;
    chk("t4_ack_count", nack, 8);
    for (int k = 0; k < nack; k++) chk("t4_order", order[k], k % 2);
    repeat (2) @(negedge clk);

    // Alignment / range behaviour.
    do_access(0, 0, 2, 0, rd, er, strb, lat);
`ifdef ALIGN_CHECK_EN
    chk("t6_a2_err", er, 1);
    chk("t6_a2_rdata", rd, 0);
    chk("t6_a2_strobe", strb, 2'b00);
    chk("t6_a2_latency", lat, 2);
    do_access(0, 0, 4092, 0, rd, er, strb, lat);
    chk("t6_4092_err", er, 0);
    chk("t6_4092_strobe", strb, 2'b01);
    do_access(0, 0, 4093, 0, rd, er, strb, lat);
    chk("t6_4093_err", er, 1);
    chk("t6_4093_strobe", strb, 2'b00);
`else
    chk("t6_a2_err", er, 0);
    chk("t6_a2_strobe", strb, 2'b01);
    do_access(0, 0, 4093, 0, rd, er, strb, lat);
    chk("t6_4093_err", er, 0);
    chk("t6_4093_strobe", strb, 2'b01);
`endif

    // Random traffic; a port only changes its fields when its request is acked.
    for (cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (bus.ack0) begin
        if ($urandom_range(0, 1) == 1) rnd_req(0); else bus.req0 = 0;
      end else if (!bus.req0 && $urandom_range(0, 2) == 0) rnd_req(0);
      if (bus.ack1) begin
        if ($urandom_range(0, 1) == 1) rnd_req(1); else bus.req1 = 0;
      end else if (!bus.req1 && $urandom_range(0, 2) == 0) rnd_req(1);
    end
    bus.req0 = 0; bus.req1 = 0;
    repeat (4) @(negedge clk);

    // Reset in the middle of an access: strobes drop at once, no ack follows.
    set_req(0, 0, 0, 0);
    @(negedge clk);
    chk("t1_pre_mem_read", bus.mem_read, 1);
    #2 rst_n = 0;
    #1 chk("t1_async_mem_read", bus.mem_read, 0);
    @(negedge clk);
    chk("t1_ack0", bus.ack0, 0);
    chk("t1_rdata0", bus.rdata0, 0);
    chk("t1_mem_read", bus.mem_read, 0);
    bus.req0 = 0;
    rst_n = 1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
